// File: rtl/adc_sar_ctrl.sv
// SAR conversion sequencer: track/hold control, MSB-first binary search on a
// synchronised comparator, result/eoc/busy/start-ack back to the SPI slave.
module adc_sar_ctrl #(
  parameter int WIDTH         = 12,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] ctrl_reg,
  input  logic             comp_in,
  output logic             sample_hold,
  output logic [WIDTH-1:0] dac_code,
  output logic [WIDTH-1:0] adc_data_out,
  output logic             adc_busy,
  output logic             adc_eoc_pulse,
  output logic             hw_clear_start
);

  // state   | meaning
  // IDLE    | waiting for ENABLE & START
  // SAMPLE  | track phase, sample_hold high
  // CONVERT | one bit trial per SETTLE_CYCLES, MSB first
  // DONE    | result published, eoc pulse
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAMPLE  = 2'd1,
    CONVERT = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int MAX_CYC = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int IDX_W   = $clog2(WIDTH);

  localparam logic [CNT_W-1:0] SAMPLE_LOAD = CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_MSB     = IDX_W'(WIDTH - 1);

  logic ctl_enable, ctl_start, ctl_cont;
  logic unused_ctrl;

  assign ctl_enable  = ctrl_reg[0];
  assign ctl_start   = ctrl_reg[1];
  assign ctl_cont    = ctrl_reg[2];
  assign unused_ctrl = ^ctrl_reg[WIDTH-1:3];

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [IDX_W-1:0] bit_idx, bit_idx_nx;
  logic [WIDTH-1:0] result_work, result_work_nx;
  logic [WIDTH-1:0] trial_bit, decided;

  logic             sample_hold_nx, busy_nx, eoc_nx, ack_nx;
  logic [WIDTH-1:0] dac_code_nx, data_nx;

  logic comp_meta, comp_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      comp_meta <= 1'b0;
      comp_s    <= 1'b0;
    end else begin
      comp_meta <= comp_in;
      comp_s    <= comp_meta;
    end
  end

  // Bits below the current trial are still zero, so OR-ing the decision in is enough.
  assign trial_bit = WIDTH'(1) << bit_idx;
  assign decided   = result_work | (trial_bit & {WIDTH{comp_s}});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= IDX_MSB;
      result_work <= '0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      bit_idx     <= bit_idx_nx;
      result_work <= result_work_nx;
    end
  end

  // Outputs are registered from the next-state decode so they line up with the state entered.
  always_comb begin
    state_nx       = state;
    cnt_nx         = cnt;
    bit_idx_nx     = bit_idx;
    result_work_nx = result_work;
    sample_hold_nx = 1'b0;
    dac_code_nx    = '0;
    busy_nx        = 1'b0;
    eoc_nx         = 1'b0;
    ack_nx         = 1'b0;
    data_nx        = adc_data_out;

    unique case (state)
      IDLE: begin
        if (ctl_enable && ctl_start) begin
          state_nx       = SAMPLE;
          cnt_nx         = SAMPLE_LOAD;
          ack_nx         = 1'b1;
          busy_nx        = 1'b1;
          sample_hold_nx = 1'b1;
        end
      end

      SAMPLE: begin
        if (!ctl_enable) begin
          state_nx = IDLE;
        end else if (cnt == '0) begin
          state_nx       = CONVERT;
          cnt_nx         = SETTLE_LOAD;
          bit_idx_nx     = IDX_MSB;
          result_work_nx = '0;
          dac_code_nx    = WIDTH'(1) << IDX_MSB;
          busy_nx        = 1'b1;
        end else begin
          cnt_nx         = cnt - CNT_W'(1);
          sample_hold_nx = 1'b1;
          busy_nx        = 1'b1;
        end
      end

      CONVERT: begin
        if (!ctl_enable) begin
          state_nx = IDLE;
        end else if (cnt == '0) begin
          result_work_nx = decided;
          busy_nx        = 1'b1;
          if (bit_idx == '0) begin
            state_nx = DONE;
            eoc_nx   = 1'b1;
            data_nx  = decided;
          end else begin
            bit_idx_nx  = bit_idx - IDX_W'(1);
            cnt_nx      = SETTLE_LOAD;
            dac_code_nx = decided | (WIDTH'(1) << (bit_idx - IDX_W'(1)));
          end
        end else begin
          cnt_nx      = cnt - CNT_W'(1);
          dac_code_nx = result_work | trial_bit;
          busy_nx     = 1'b1;
        end
      end

      DONE: begin
        if (ctl_enable && ctl_cont) begin
          state_nx       = SAMPLE;
          cnt_nx         = SAMPLE_LOAD;
          sample_hold_nx = 1'b1;
          busy_nx        = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_hold    <= 1'b0;
      dac_code       <= '0;
      adc_data_out   <= '0;
      adc_busy       <= 1'b0;
      adc_eoc_pulse  <= 1'b0;
      hw_clear_start <= 1'b0;
    end else begin
      sample_hold    <= sample_hold_nx;
      dac_code       <= dac_code_nx;
      adc_data_out   <= data_nx;
      adc_busy       <= busy_nx;
      adc_eoc_pulse  <= eoc_nx;
      hw_clear_start <= ack_nx;
    end
  end

endmodule

// File: tb/tb_adc_sar_ctrl.sv
// Directed bench for adc_sar_ctrl with an ideal comparator against a fixed VIN.
module tb_adc_sar_ctrl;

  logic        clk;
  logic        reset;
  logic [11:0] ctrl_reg;
  logic        comp_in;
  logic        sample_hold;
  logic [11:0] dac_code;
  logic [11:0] adc_data_out;
  logic        adc_busy;
  logic        adc_eoc_pulse;
  logic        hw_clear_start;
  logic [11:0] vin;

  int checks;
  int failures;

  adc_sar_ctrl #(.WIDTH(12), .SAMPLE_CYCLES(4), .SETTLE_CYCLES(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .ctrl_reg       (ctrl_reg),
    .comp_in        (comp_in),
    .sample_hold    (sample_hold),
    .dac_code       (dac_code),
    .adc_data_out   (adc_data_out),
    .adc_busy       (adc_busy),
    .adc_eoc_pulse  (adc_eoc_pulse),
    .hw_clear_start (hw_clear_start)
  );

  assign comp_in = (vin >= dac_code);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Single-shot conversion; k counts negedges after the edge that samples START.
  task automatic conv(input logic [11:0] vin_v, input string tag, input bit trace);
    int ack_k, eoc_k, low_k, ack_cnt, overlap;
    ack_k = -1; eoc_k = -1; low_k = -1; ack_cnt = 0; overlap = 0;
    vin = vin_v;
    ctrl_reg = 12'h003;
    for (int k = 0; k < 80 && low_k < 0; k++) begin
      @(negedge clk);
      if (hw_clear_start) begin
        ack_cnt++;
        if (ack_k < 0) ack_k = k;
        ctrl_reg = 12'h001;
      end
      if (hw_clear_start && adc_eoc_pulse) overlap++;
      if (adc_eoc_pulse && eoc_k < 0) eoc_k = k;
      if (eoc_k >= 0 && k > eoc_k && !adc_busy) low_k = k;
      if (trace) begin
        if (k == 3) chk({tag, "_sh_k3"}, 32'(sample_hold), 32'd1);
        if (k == 4) chk({tag, "_sh_k4"}, 32'(sample_hold), 32'd0);
        if (k >= 4 && k < 40 && ((k - 4) % 3) == 0)
          chk($sformatf("%s_dac_bit%0d", tag, 11 - (k - 4) / 3), 32'(dac_code),
              32'(1) << (11 - (k - 4) / 3));
      end
    end
    chk({tag, "_ack_k"}, 32'(ack_k), 32'd0);
    chk({tag, "_eoc_k"}, 32'(eoc_k), 32'd40);
    chk({tag, "_busy_low_k"}, 32'(low_k), 32'd41);
    chk({tag, "_data"}, 32'(adc_data_out), 32'(vin_v));
    chk({tag, "_ack_cnt"}, 32'(ack_cnt), 32'd1);
    chk({tag, "_ack_eoc_overlap"}, 32'(overlap), 32'd0);
    ctrl_reg = 12'h000;
    @(negedge clk);
  endtask

  initial begin
    int eoc_ks[4];
    int n_eoc, ack_cnt, low_k, ack2_k, eoc_seen;
    checks = 0;
    failures = 0;
    vin = 12'h000;
    ctrl_reg = 12'h000;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {12'd0, adc_data_out, sample_hold, adc_busy, adc_eoc_pulse, hw_clear_start, 4'd0},
        32'd0);
    chk("rst_dac", 32'(dac_code), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // START without ENABLE: ignored
    ctrl_reg = 12'h002;
    repeat (4) @(negedge clk);
    chk("start_no_en_busy", {30'd0, adc_busy, hw_clear_start}, 32'd0);
    ctrl_reg = 12'h000;
    @(negedge clk);

    conv(12'hA5C, "t1", 1'b0);
    conv(12'h000, "t2_zero", 1'b1);
    conv(12'hFFF, "t2_full", 1'b0);

    // Continuous mode; CONT dropped during the fourth conversion
    vin = 12'h123;
    ctrl_reg = 12'h007;
    n_eoc = 0; ack_cnt = 0; low_k = -1;
    for (int k = 0; k < 180 && low_k < 0; k++) begin
      @(negedge clk);
      if (k == 0) ctrl_reg = 12'h005;
      if (k == 125) ctrl_reg = 12'h001;
      if (hw_clear_start) ack_cnt++;
      if (adc_eoc_pulse && n_eoc < 4) begin
        eoc_ks[n_eoc] = k;
        n_eoc++;
      end
      if (!adc_busy) low_k = k;
    end
    chk("t3_eoc_count", 32'(n_eoc), 32'd4);
    chk("t3_eoc0", 32'(eoc_ks[0]), 32'd40);
    chk("t3_eoc1", 32'(eoc_ks[1]), 32'd81);
    chk("t3_eoc2", 32'(eoc_ks[2]), 32'd122);
    chk("t3_eoc3", 32'(eoc_ks[3]), 32'd163);
    chk("t3_busy_low_k", 32'(low_k), 32'd164);
    chk("t3_ack_cnt", 32'(ack_cnt), 32'd1);
    chk("t3_data", 32'(adc_data_out), 32'h123);
    ctrl_reg = 12'h000;
    @(negedge clk);

    // Abort on ENABLE low at the 20th CONVERT cycle
    conv(12'hA5C, "t4_pre", 1'b0);
    vin = 12'h3FF;
    ctrl_reg = 12'h003;
    for (int k = 0; k <= 23; k++) begin
      @(negedge clk);
      if (k == 0) ctrl_reg = 12'h001;
    end
    chk("t4_busy_before", 32'(adc_busy), 32'd1);
    ctrl_reg = 12'h000;
    @(negedge clk);
    chk("t4_busy", 32'(adc_busy), 32'd0);
    chk("t4_dac", 32'(dac_code), 32'd0);
    chk("t4_sh", 32'(sample_hold), 32'd0);
    chk("t4_data", 32'(adc_data_out), 32'hA5C);
    eoc_seen = 0;
    repeat (50) begin
      @(negedge clk);
      if (adc_eoc_pulse) eoc_seen++;
    end
    chk("t4_no_eoc", 32'(eoc_seen), 32'd0);

    // START re-asserted while busy
    vin = 12'h6B1;
    ctrl_reg = 12'h003;
    n_eoc = 0; ack_cnt = 0; ack2_k = -1;
    for (int k = 0; k < 90; k++) begin
      @(negedge clk);
      if (k == 10) ctrl_reg = 12'h003;
      if (hw_clear_start) begin
        ack_cnt++;
        if (ack_cnt == 2) ack2_k = k;
        ctrl_reg = 12'h001;
      end
      if (adc_eoc_pulse && n_eoc < 4) begin
        eoc_ks[n_eoc] = k;
        n_eoc++;
      end
    end
    chk("t5_ack_cnt", 32'(ack_cnt), 32'd2);
    chk("t5_ack2_k", 32'(ack2_k), 32'd42);
    chk("t5_eoc_count", 32'(n_eoc), 32'd2);
    chk("t5_eoc0", 32'(eoc_ks[0]), 32'd40);
    chk("t5_eoc1", 32'(eoc_ks[1]), 32'd82);
    chk("t5_data", 32'(adc_data_out), 32'h6B1);
    ctrl_reg = 12'h000;
    @(negedge clk);

    // Async reset mid-CONVERT
    vin = 12'hA5C;
    ctrl_reg = 12'h003;
    for (int k = 0; k <= 15; k++) begin
      @(negedge clk);
      if (k == 0) ctrl_reg = 12'h001;
    end
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_ctl", {28'd0, sample_hold, adc_busy, adc_eoc_pulse, hw_clear_start}, 32'd0);
    chk("t6_rst_dac", 32'(dac_code), 32'd0);
    chk("t6_rst_data", 32'(adc_data_out), 32'd0);
    ctrl_reg = 12'h000;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    conv(12'h5A5, "t6_post", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
